// File: rtl/seq_nibble_mul.sv
// Iterative WIDTH x WIDTH unsigned multiplier driving one external 4x4 core, one nibble pair per cycle.
// Optional macro ZERO_SKIP_EN: pairs with a zero nibble are skipped at no cycle cost.
module seq_nibble_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [3:0]         mul_a,
  output logic [3:0]         mul_b,
  input  logic [7:0]         mul_r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int unsigned K  = WIDTH / 4;
  localparam int unsigned NP = K * K;
  localparam int unsigned CW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_q, b_q, a_next, b_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [PW-1:0]   acc, acc_next, out_p_next, term;
  logic            out_valid_next;
  int unsigned     idx_a, idx_b;

`ifdef ZERO_SKIP_EN
  logic [CW:0] nz;

  // First pair index >= from with both nibbles nonzero; MSB flags that one was found.
  function automatic logic [CW:0] first_nz(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input int unsigned from);
    logic [CW:0] r;
    r = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      if (!r[CW] && p >= from &&
          4'(a >> (4 * (p % K))) != 4'd0 &&
          4'(b >> (4 * (p / K))) != 4'd0)
        r = {1'b1, CW'(p)};
    end
    return r;
  endfunction
`endif

  // Next-state, datapath and core-operand decode
  always_comb begin
    state_next     = state;
    a_next         = a_q;
    b_next         = b_q;
    cnt_next       = cnt;
    acc_next       = acc;
    out_p_next     = out_p;
    out_valid_next = out_valid;
    mul_a          = 4'd0;
    mul_b          = 4'd0;
    idx_a          = 32'(cnt) % K;
    idx_b          = 32'(cnt) / K;
    term           = PW'(mul_r) << (4 * (idx_a + idx_b));
`ifdef ZERO_SKIP_EN
    nz             = '0;
`endif
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_next   = in_a;
          b_next   = in_b;
          acc_next = '0;
`ifdef ZERO_SKIP_EN
          nz = first_nz(in_a, in_b, 0);
          if (nz[CW]) begin
            cnt_next   = nz[CW-1:0];
            state_next = RUN;
          end else begin
            cnt_next       = '0;
            out_p_next     = '0;
            out_valid_next = 1'b1;
            state_next     = DONE;
          end
`else
          cnt_next   = '0;
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        mul_a    = 4'(a_q >> (4 * idx_a));
        mul_b    = 4'(b_q >> (4 * idx_b));
        acc_next = acc + term;
`ifdef ZERO_SKIP_EN
        nz = first_nz(a_q, b_q, 32'(cnt) + 1);
        if (nz[CW]) begin
          cnt_next = nz[CW-1:0];
        end else begin
          out_p_next     = acc + term;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
`else
        if (cnt == CW'(NP - 1)) begin
          out_p_next     = acc + term;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; handshake flags follow the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      a_q       <= a_next;
      b_q       <= b_next;
      cnt       <= cnt_next;
      acc       <= acc_next;
      out_p     <= out_p_next;
      out_valid <= out_valid_next;
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_seq_nibble_mul.sv
// Scoreboard bench for seq_nibble_mul (WIDTH=8) with exact, stub and approximate 4x4 cores.
module tb_seq_nibble_mul;

  localparam int unsigned WIDTH = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic [3:0]        mul_a, mul_b;
  logic [7:0]        mul_r;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*WIDTH-1:0] out_p;
  logic              busy;

  typedef struct {
    logic [15:0] p;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pair_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         core_mode = 0;  // 0 exact, 1 constant 0xFF stub, 2 approximate

  seq_nibble_mul #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] core_fn(input logic [3:0] a, input logic [3:0] b, input int mode);
    logic [7:0] x;
    x = 8'(a) * 8'(b);
    if (mode == 1) return 8'hFF;
    if (mode == 2) return x | 8'h01;
    return x;
  endfunction

  assign mul_r = core_fn(mul_a, mul_b, core_mode);

  // Reference: sum of core products of every processed nibble pair, weighted by nibble position
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input int mode);
    logic [15:0] s;
    logic [3:0]  na, nb;
    if (mode == 0) return 16'(a) * 16'(b);
    s = '0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++) begin
        na = 4'(a >> (4 * i));
        nb = 4'(b >> (4 * j));
`ifdef ZERO_SKIP_EN
        if (na != 4'd0 && nb != 4'd0)
          s = s + (16'(core_fn(na, nb, mode)) << (4 * (i + j)));
`else
        s = s + (16'(core_fn(na, nb, mode)) << (4 * (i + j)));
`endif
      end
    return s;
  endfunction

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef ZERO_SKIP_EN
    int n;
    n = 0;
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++)
        if (4'(a >> (4 * i)) != 4'd0 && 4'(b >> (4 * j)) != 4'd0) n++;
    return n + 1;
`else
    return 5;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair and hold it until accepted; the expectation is queued at acceptance
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   n;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (!in_ready) begin
      fail_now("send_timeout");
    end else begin
      e.p = model(a, b, core_mode);
      e.lat = exp_lat(a, b);
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && sb.size() == 0) && n < 300) begin
      step();
      n++;
    end
    if (!(in_ready && sb.size() == 0)) fail_now("wait_idle_timeout");
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int mode);
    core_mode = mode;
    out_ready = 1'b1;
    send(a, b);
    wait_idle();
  endtask

  // Monitor: compares latency and product against the scoreboard, checks hold and core-operand rules
  logic        prev_ov = 1'b0;
  logic        prev_or = 1'b0;
  logic [15:0] prev_p = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (!busy || out_valid) check("mul_zero_outside_run", 32'({mul_a, mul_b}), 32'd0);
      if (busy && !out_valid) pair_q.push_back({mul_a, mul_b});
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) fail_now("unexpected_out_valid");
        else check("latency", 32'(cyc - sb[0].acc_cyc + 1), 32'(sb[0].lat));
      end
      if (out_valid && prev_ov && !prev_or) check("out_p_hold", 32'(out_p), 32'(prev_p));
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        check("out_p", 32'(out_p), 32'(e.p));
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_p  = out_p;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_at[3];
    int na, n;
    logic [7:0] ra, rb;

    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_p", 32'(out_p), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Nibble-pair order and basic products
    pair_q.delete();
    run_op(8'hAB, 8'hCD, 0);
    check("pair_count", 32'(pair_q.size()), 32'd4);
    if (pair_q.size() == 4) begin
      check("pair0", 32'(pair_q[0]), 32'hBD);
      check("pair1", 32'(pair_q[1]), 32'hAD);
      check("pair2", 32'(pair_q[2]), 32'hBC);
      check("pair3", 32'(pair_q[3]), 32'hAC);
    end
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'hFF, 8'h77, 1);
    run_op(8'h00, 8'h37, 0);
    run_op(8'h10, 8'h01, 0);
    run_op(8'h9C, 8'h5E, 2);

    // Back-to-back with in_valid held high
    core_mode = 0;
    out_ready = 1'b1;
    in_a = 8'h5A;
    in_b = 8'h3C;
    in_valid = 1'b1;
    na = 0;
    n = 0;
    while (na < 3 && n < 60) begin
      if (in_ready) begin
        exp_t e;
        e.p = model(8'h5A, 8'h3C, 0);
        e.lat = exp_lat(8'h5A, 8'h3C);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        acc_at[na] = cyc + 1;
        na++;
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    if (na < 3) begin
      fail_now("b2b_accept_timeout");
    end else begin
      check("b2b_spacing0", 32'(acc_at[1] - acc_at[0]), 32'(exp_lat(8'h5A, 8'h3C) + 1));
      check("b2b_spacing1", 32'(acc_at[2] - acc_at[1]), 32'(exp_lat(8'h5A, 8'h3C) + 1));
    end
    wait_idle();

    // Backpressure in DONE with ignored in_valid pulses
    out_ready = 1'b0;
    send(8'h3E, 8'hB7);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (!out_valid) fail_now("bp_out_valid_timeout");
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      step();
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_in_ready_after_hs", 32'(in_ready), 32'd1);
    check("bp_out_valid_after_hs", 32'(out_valid), 32'd0);
    wait_idle();

    // Reset on the second RUN cycle discards the operation
    send(8'h12, 8'h34);
    step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_p", 32'(out_p), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    run_op(8'h02, 8'h03, 0);

    // Randomized operands, cores and consumer stalls
    for (int t = 0; t < 40; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra[3:0] = 4'd0;
      if ($urandom_range(0, 3) == 0) ra[7:4] = 4'd0;
      if ($urandom_range(0, 3) == 0) rb[3:0] = 4'd0;
      if ($urandom_range(0, 3) == 0) rb[7:4] = 4'd0;
      core_mode = int'($urandom_range(0, 2));
      out_ready = 1'($urandom_range(0, 1));
      send(ra, rb);
      n = 0;
      while (sb.size() != 0 && n < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      if (sb.size() != 0) fail_now("random_drain_timeout");
      out_ready = 1'b1;
      wait_idle();
    end

    repeat (5) step();
    check("final_scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
